voice_allocator: RTL and testbench

//  Shares NVOICE tone-generator voices among the 12 note keys of the current octave.

---
 rtl/voice_allocator.sv | 149 ++++++++++++++
 tb/tb_voice_allocator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Shares NVOICE tone-generator voices among the 12 note keys by scanning one key per cycle.
// Define VOICE_STEAL_EN to steal the oldest voice when all are busy; otherwise a blocked press pulses drop.
module voice_allocator #(
  parameter int unsigned NVOICE = 4,
  parameter int unsigned DW     = 18
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [11:0]            keys,
  input  logic [12*DW-1:0]       div_flat,
  output logic [NVOICE-1:0]      voice_en,
  output logic [NVOICE*4-1:0]    voice_key,
  output logic [NVOICE*DW-1:0]   voice_div,
  output logic                   drop
);

  localparam int unsigned AW       = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam int unsigned VW       = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam int unsigned LAST_KEY = 11;
  localparam logic [AW-1:0] AMAX   = AW'(NVOICE - 1);

  logic [3:0]        scan_r, scan_n;
  logic [NVOICE-1:0] en_r, en_n;
  logic [3:0]        key_r [NVOICE];
  logic [3:0]        key_n [NVOICE];
  logic [AW-1:0]     age_r [NVOICE];
  logic [AW-1:0]     age_n [NVOICE];
  logic              drop_r, drop_n;

  logic [15:0]       keys_pad;
  logic              pressed;
  logic              hit;
  logic [VW-1:0]     hit_idx;
  logic [AW-1:0]     hit_age;
  logic              any_free;
  logic [VW-1:0]     free_idx;
`ifdef VOICE_STEAL_EN
  logic [VW-1:0]     old_idx;
`endif

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] a);
    return (a == AMAX) ? a : a + AW'(1);
  endfunction

  assign keys_pad = {4'b0000, keys};
  assign pressed  = keys_pad[scan_r];

  // Lookup of the voice bound to the scanned key, the lowest free voice and the oldest voice
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_age  = '0;
    any_free = 1'b0;
    free_idx = '0;
`ifdef VOICE_STEAL_EN
    old_idx  = '0;
`endif
    for (int v = NVOICE - 1; v >= 0; v--) begin
      if (!en_r[v]) begin
        any_free = 1'b1;
        free_idx = VW'(v);
      end
      if (en_r[v] && (key_r[v] == scan_r)) begin
        hit     = 1'b1;
        hit_idx = VW'(v);
        hit_age = age_r[v];
      end
`ifdef VOICE_STEAL_EN
      if (en_r[v] && (age_r[v] == AMAX)) old_idx = VW'(v);
`endif
    end
  end

  // Next-state for the key under scan: alloc, release, steal or drop
  always_comb begin
    scan_n = (scan_r == 4'(LAST_KEY)) ? 4'd0 : scan_r + 4'd1;
    en_n   = en_r;
    key_n  = key_r;
    age_n  = age_r;
    drop_n = 1'b0;
    if (pressed && !hit) begin
      if (any_free) begin
        for (int v = 0; v < NVOICE; v++) begin
          if (en_r[v]) age_n[v] = sat_inc(age_r[v]);
        end
        en_n[free_idx]  = 1'b1;
        key_n[free_idx] = scan_r;
        age_n[free_idx] = '0;
      end else begin
`ifdef VOICE_STEAL_EN
        for (int v = 0; v < NVOICE; v++) begin
          age_n[v] = sat_inc(age_r[v]);
        end
        key_n[old_idx] = scan_r;
        age_n[old_idx] = '0;
`else
        drop_n = 1'b1;
`endif
      end
    end else if (!pressed && hit) begin
      // Close the gap in the age ordering left by the released voice
      for (int v = 0; v < NVOICE; v++) begin
        if (en_r[v] && (age_r[v] > hit_age)) age_n[v] = age_r[v] - AW'(1);
      end
      en_n[hit_idx]  = 1'b0;
      age_n[hit_idx] = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      scan_r <= '0;
      en_r   <= '0;
      drop_r <= 1'b0;
      for (int v = 0; v < NVOICE; v++) begin
        key_r[v] <= '0;
        age_r[v] <= '0;
      end
    end else begin
      scan_r <= scan_n;
      en_r   <= en_n;
      drop_r <= drop_n;
      for (int v = 0; v < NVOICE; v++) begin
        key_r[v] <= key_n[v];
        age_r[v] <= age_n[v];
      end
    end
  end

  // Divider table padded to 16 entries so the 4-bit key index is always in range
  logic [DW-1:0] div_arr [16];
  for (genvar k = 0; k < 16; k++) begin : g_div
    if (k < 12) begin : g_real
      assign div_arr[k] = div_flat[k*DW +: DW];
    end else begin : g_pad
      assign div_arr[k] = '0;
    end
  end

  // Divider routing follows div_flat combinationally so octave changes retune at once
  for (genvar v = 0; v < NVOICE; v++) begin : g_out
    assign voice_key[v*4 +: 4]   = key_r[v];
    assign voice_div[v*DW +: DW] = en_r[v] ? div_arr[key_r[v]] : '0;
  end

  assign voice_en = en_r;
  assign drop     = drop_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NVOICE=4, divider k = 1000+k); table of 12-cycle-aligned
// vectors plus hand sequences for drop/steal timing, retune, mid-run reset and short presses.
module tb_voice_allocator;

  localparam int unsigned NVOICE = 4;
  localparam int unsigned DW     = 18;

  logic                 clk;
  logic                 nrst;
  logic [11:0]          keys;
  logic [12*DW-1:0]     div_flat;
  logic [NVOICE-1:0]    voice_en;
  logic [NVOICE*4-1:0]  voice_key;
  logic [NVOICE*DW-1:0] voice_div;
  logic                 drop;

  int nvec;
  int nfail;

  voice_allocator #(.NVOICE(NVOICE), .DW(DW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .keys      (keys),
    .div_flat  (div_flat),
    .voice_en  (voice_en),
    .voice_key (voice_key),
    .voice_div (voice_div),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] keys;
    int          cycles;
    logic [3:0]  en;
    logic [15:0] key;
    int          drops;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] exp_div(input logic [3:0] en, input logic [15:0] kp);
    logic [4*DW-1:0] r;
    r = '0;
    for (int v = 0; v < 4; v++) begin
      if (en[v]) r[v*DW +: DW] = DW'(1000 + int'(kp[v*4 +: 4]));
    end
    return r;
  endfunction

  // Each iteration crosses exactly one active edge; outputs sampled on the falling edge
  task automatic run(input int n, output int drops);
    drops = 0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (drop) drops++;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic set_base_divs();
    for (int k = 0; k < 12; k++) div_flat[k*DW +: DW] = DW'(1000 + k);
  endtask

  int d;

  initial begin
    nvec  = 0;
    nfail = 0;
    keys  = '0;
    nrst  = 1'b0;
    set_base_divs();

    tbl[0] = '{keys: 12'h000, cycles: 24, en: 4'b0000, key: 16'h0000, drops: 0};
    tbl[1] = '{keys: 12'h001, cycles: 12, en: 4'b0001, key: 16'h0000, drops: 0};
    tbl[2] = '{keys: 12'h000, cycles: 12, en: 4'b0000, key: 16'h0000, drops: 0};
    tbl[3] = '{keys: 12'h00F, cycles: 12, en: 4'b1111, key: 16'h3210, drops: 0};
`ifdef VOICE_STEAL_EN
    tbl[4] = '{keys: 12'h01F, cycles: 12, en: 4'b1111, key: 16'h3214, drops: 0};
`else
    tbl[4] = '{keys: 12'h01F, cycles: 12, en: 4'b1111, key: 16'h3210, drops: 1};
`endif
    tbl[5] = '{keys: 12'h016, cycles: 12, en: 4'b0111, key: 16'h3214, drops: 0};
    tbl[6] = '{keys: 12'h000, cycles: 12, en: 4'b0000, key: 16'h3214, drops: 0};

    @(negedge clk);
    check("reset_en",   128'(voice_en),  128'(0));
    check("reset_key",  128'(voice_key), 128'(0));
    check("reset_div",  128'(voice_div), 128'(0));
    check("reset_drop", 128'(drop),      128'(0));
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      keys = tbl[i].keys;
      run(tbl[i].cycles, d);
      check($sformatf("v%0d_en", i),    128'(voice_en),  128'(tbl[i].en));
      check($sformatf("v%0d_key", i),   128'(voice_key), 128'(tbl[i].key));
      check($sformatf("v%0d_div", i),   128'(voice_div), 128'(exp_div(tbl[i].en, tbl[i].key)));
      check($sformatf("v%0d_drops", i), 128'(d),         128'(tbl[i].drops));
    end

    // Blocked fifth key: first evaluated on edge 5 after reset
    keys = 12'h01F;
    do_reset();
    run(4, d);
    check("full_en",  128'(voice_en),  128'(4'b1111));
    check("full_key", 128'(voice_key), 128'(16'h3210));
    run(1, d);
`ifdef VOICE_STEAL_EN
    check("steal_key",  128'(voice_key),         128'(16'h3214));
    check("steal_div0", 128'(voice_div[0 +: DW]), 128'(1004));
    check("steal_en",   128'(voice_en),          128'(4'b1111));
    check("steal_drop", 128'(drop),              128'(0));
`else
    check("drop_pulse1", 128'(drop),      128'(1));
    check("drop_nochg",  128'(voice_key), 128'(16'h3210));
    run(11, d);
    check("drop_gap",    128'(d),         128'(0));
    run(1, d);
    check("drop_pulse2", 128'(drop),      128'(1));
    check("drop_en",     128'(voice_en),  128'(4'b1111));
`endif

    // Octave retune on a sounding voice, visible before the next edge
    keys = 12'h00F;
    do_reset();
    run(12, d);
    div_flat[2*DW +: DW] = DW'(2002);
    #1;
    check("retune_div2", 128'(voice_div[2*DW +: DW]), 128'(2002));
    check("retune_en",   128'(voice_en),              128'(4'b1111));
    check("retune_div1", 128'(voice_div[1*DW +: DW]), 128'(1001));
    set_base_divs();

    // Mid-run reset silences at once and scanning restarts at key 0
    keys = 12'h007;
    do_reset();
    run(12, d);
    check("pre_rst_en", 128'(voice_en), 128'(4'b0111));
    #2;
    nrst = 1'b0;
    #1;
    check("rst_en",  128'(voice_en),  128'(0));
    check("rst_div", 128'(voice_div), 128'(0));
    check("rst_key", 128'(voice_key), 128'(0));
    @(negedge clk);
    nrst = 1'b1;
    run(1, d);
    check("restart_en1", 128'(voice_en), 128'(4'b0001));
    run(2, d);
    check("restart_en3", 128'(voice_en), 128'(4'b0111));

    // Press of key 5 that lands entirely between two scans of index 5
    keys = 12'h000;
    do_reset();
    run(7, d);
    keys = 12'h020;
    run(8, d);
    check("short_en_held", 128'(voice_en), 128'(0));
    keys = 12'h000;
    run(9, d);
    check("short_en",    128'(voice_en), 128'(0));
    check("short_drops", 128'(d),        128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
